gate_resp_checker: RTL and testbench

- Response side of the 2-input gate stimulus flow; the existing gate bench drives a/b vectors, and this block checks what comes back.
- Accepts one a/b vector per handshake, waits a settle interval, then samples the gate output c.
- Compares c against the expected value for a selected gate function (OR/AND/XOR/NAND).
- Keeps pass/fail counters, a sticky error flag and a 4-entry input-coverage map; sits beside a gate under test in sim or on-board self-test.

---
 rtl/gate_chk_pkg.sv | 27 ++
 rtl/sat_counter.sv | 31 +++
 rtl/gate_resp_checker.sv | 171 +++++++++++++++++
 tb/tb_gate_resp_checker.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_chk_pkg.sv
// Shared definitions for the gate response checker: op encodings, FSM states
// and the reference gate function.
package gate_chk_pkg;

  localparam logic [1:0] OP_OR   = 2'd0;
  localparam logic [1:0] OP_AND  = 2'd1;
  localparam logic [1:0] OP_XOR  = 2'd2;
  localparam logic [1:0] OP_NAND = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_REPORT = 2'd2
  } state_e;

  function automatic logic exp_c(input logic [1:0] op, input logic a, input logic b);
    logic r;
    case (op)
      OP_OR:   r = a | b;
      OP_AND:  r = a & b;
      OP_XOR:  r = a ^ b;
      default: r = ~(a & b);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clr has priority over inc.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != '1))
      cnt_d = cnt_q + ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/gate_resp_checker.sv
// Checks a 2-input gate's response: accept a/b, wait SETTLE_CYC, sample obs_c.
// Optional first-mismatch capture port enabled by GATE_CHK_FIRST_FAIL_EN.
//
// state     | meaning
// ST_IDLE   | vec_ready high, waiting for a vector
// ST_SETTLE | vector captured, settle timer running down to zero
// ST_REPORT | result_valid pulse, back to idle on next edge
module gate_resp_checker
  import gate_chk_pkg::*;
#(
  parameter int SETTLE_CYC = 3,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [1:0]       op_sel,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic             vec_a,
  input  logic             vec_b,
  input  logic             obs_c,
  output logic             result_valid,
  output logic             result_pass,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err_sticky,
  output logic [3:0]       cov_map,
  output logic             cov_done
`ifdef GATE_CHK_FIRST_FAIL_EN
  ,output logic [4:0]      first_fail_vec
`endif
);

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYC - 1);

  state_e     state_q, state_d;
  logic [7:0] tmr_q, tmr_d;
  logic       a_q, a_d, b_q, b_d;
  logic [1:0] op_q, op_d;
  logic       ready_q, ready_d;
  logic       rv_q, rv_d;
  logic       rp_q, rp_d;
  logic       err_q, err_d;
  logic [3:0] cov_q, cov_d;
  logic       sample, match;

  // sample is the edge that ends SETTLE; a clear on that edge drops the check
  assign sample = (state_q == ST_SETTLE) && (tmr_q == 8'd0) && !clear;
  assign match  = (obs_c == exp_c(op_q, a_q, b_q));

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    ready_d = ready_q;
    rv_d    = rv_q;
    rp_d    = rp_q;
    err_d   = err_q;
    cov_d   = cov_q;
    if (clear) begin
      state_d = ST_IDLE;
      ready_d = 1'b1;
      rv_d    = 1'b0;
      err_d   = 1'b0;
      cov_d   = 4'b0000;
    end else begin
      case (state_q)
        ST_IDLE: begin
          rv_d = 1'b0;
          if (vec_valid && ready_q) begin
            a_d     = vec_a;
            b_d     = vec_b;
            op_d    = op_sel;
            tmr_d   = SETTLE_LOAD;
            ready_d = 1'b0;
            state_d = ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (tmr_q == 8'd0) begin
            rp_d             = match;
            err_d            = err_q | ~match;
            cov_d[{a_q, b_q}] = 1'b1;
            rv_d             = 1'b1;
            state_d          = ST_REPORT;
          end else begin
            tmr_d = tmr_q - 8'd1;
          end
        end
        default: begin
          rv_d    = 1'b0;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tmr_q   <= 8'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      op_q    <= OP_OR;
      ready_q <= 1'b1;
      rv_q    <= 1'b0;
      rp_q    <= 1'b0;
      err_q   <= 1'b0;
      cov_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      ready_q <= ready_d;
      rv_q    <= rv_d;
      rp_q    <= rp_d;
      err_q   <= err_d;
      cov_q   <= cov_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_pass_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .inc   (sample & match),
    .cnt   (pass_cnt)
  );

  sat_counter #(.W(CNT_W)) u_fail_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .inc   (sample & ~match),
    .cnt   (fail_cnt)
  );

`ifdef GATE_CHK_FIRST_FAIL_EN
  logic [4:0] ffv_q, ffv_d;

  // bit 4 doubles as the "already captured" marker
  always_comb begin
    ffv_d = ffv_q;
    if (clear)
      ffv_d = 5'b0;
    else if (sample && !match && !ffv_q[4])
      ffv_d = {1'b1, op_q, a_q, b_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ffv_q <= 5'b0;
    else        ffv_q <= ffv_d;
  end

  assign first_fail_vec = ffv_q;
`endif

  assign vec_ready    = ready_q;
  assign result_valid = rv_q;
  assign result_pass  = rp_q;
  assign err_sticky   = err_q;
  assign cov_map      = cov_q;
  assign cov_done     = (cov_q == 4'b1111);

endmodule

// File: tb/tb_gate_resp_checker.sv
// Directed bench for gate_resp_checker (SETTLE_CYC=3, CNT_W=8).
module tb_gate_resp_checker;
  import gate_chk_pkg::*;

  logic       clk, rst_n, clear, vec_valid, vec_a, vec_b, obs_c;
  logic [1:0] op_sel;
  logic       vec_ready, result_valid, result_pass, err_sticky, cov_done;
  logic [7:0] pass_cnt, fail_cnt;
  logic [3:0] cov_map;
`ifdef GATE_CHK_FIRST_FAIL_EN
  logic [4:0] first_fail_vec;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  gate_resp_checker #(.SETTLE_CYC(3), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .op_sel       (op_sel),
    .vec_valid    (vec_valid),
    .vec_ready    (vec_ready),
    .vec_a        (vec_a),
    .vec_b        (vec_b),
    .obs_c        (obs_c),
    .result_valid (result_valid),
    .result_pass  (result_pass),
    .pass_cnt     (pass_cnt),
    .fail_cnt     (fail_cnt),
    .err_sticky   (err_sticky),
    .cov_map      (cov_map),
    .cov_done     (cov_done)
`ifdef GATE_CHK_FIRST_FAIL_EN
    ,.first_fail_vec (first_fail_vec)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  // Offers one vector, returns settle latency (-1 on timeout) and the cycle of the result pulse.
  task automatic run_vec(input logic a, input logic b, input logic [1:0] op, input logic c,
                         output int lat, output int rv_cyc);
    int waits = 0;
    vec_a = a; vec_b = b; op_sel = op; obs_c = c; vec_valid = 1'b1;
    while (!vec_ready && waits < 50) begin
      @(posedge clk); #1;
      waits++;
    end
    @(posedge clk); #1;
    vec_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk); #1;
      if (result_valid) begin
        lat = i;
        break;
      end
    end
    rv_cyc = cyc;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; vec_valid = 1'b0; vec_a = 1'b0; vec_b = 1'b0;
    obs_c = 1'b0; op_sel = OP_OR;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (vec_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", vec_ready); end
    checks++; if (result_valid !== 1'b0 || result_pass !== 1'b0) begin failures++; $display("FAIL reset_result: got rv=%b rp=%b expected 0/0", result_valid, result_pass); end
    checks++; if (pass_cnt !== 8'd0 || fail_cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", pass_cnt, fail_cnt); end
    checks++; if (err_sticky !== 1'b0 || cov_map !== 4'b0 || cov_done !== 1'b0) begin failures++; $display("FAIL reset_flags: got err=%b cov=%b done=%b expected 0/0000/0", err_sticky, cov_map, cov_done); end
`ifdef GATE_CHK_FIRST_FAIL_EN
    checks++; if (first_fail_vec !== 5'b0) begin failures++; $display("FAIL reset_ffv: got %b expected 00000", first_fail_vec); end
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_or_sweep();
    int lat, rvc, prev_rvc;
    logic [1:0] v;
    prev_rvc = 0;
    for (int i = 0; i < 4; i++) begin
      v = 2'(i);
      run_vec(v[1], v[0], OP_OR, v[1] | v[0], lat, rvc);
      checks++; if (lat !== 3) begin failures++; $display("FAIL or_latency[%0d]: got %0d expected 3", i, lat); end
      checks++; if (result_pass !== 1'b1) begin failures++; $display("FAIL or_pass[%0d]: got %b expected 1", i, result_pass); end
      checks++; if (result_valid !== 1'b0 || vec_ready !== 1'b1) begin failures++; $display("FAIL or_pulse_end[%0d]: got rv=%b rdy=%b expected 0/1", i, result_valid, vec_ready); end
      if (i > 0) begin
        checks++; if (rvc - prev_rvc !== 5) begin failures++; $display("FAIL or_spacing[%0d]: got %0d expected 5", i, rvc - prev_rvc); end
      end
      prev_rvc = rvc;
    end
    checks++; if (pass_cnt !== 8'd4 || fail_cnt !== 8'd0) begin failures++; $display("FAIL or_counts: got %0d/%0d expected 4/0", pass_cnt, fail_cnt); end
    checks++; if (cov_map !== 4'b1111 || cov_done !== 1'b1 || err_sticky !== 1'b0) begin failures++; $display("FAIL or_cov: got cov=%b done=%b err=%b expected 1111/1/0", cov_map, cov_done, err_sticky); end
  endtask

  task automatic test_fault();
    int lat, rvc;
    do_clear();
    checks++; if (pass_cnt !== 8'd0 || cov_map !== 4'b0 || cov_done !== 1'b0) begin failures++; $display("FAIL clear_state: got pass=%0d cov=%b done=%b expected 0/0000/0", pass_cnt, cov_map, cov_done); end
    run_vec(1'b1, 1'b0, OP_OR, 1'b0, lat, rvc);
    checks++; if (result_pass !== 1'b0) begin failures++; $display("FAIL fault_pass: got %b expected 0", result_pass); end
    checks++; if (fail_cnt !== 8'd1 || pass_cnt !== 8'd0) begin failures++; $display("FAIL fault_cnt: got fail=%0d pass=%0d expected 1/0", fail_cnt, pass_cnt); end
    checks++; if (err_sticky !== 1'b1 || cov_map !== 4'b0100) begin failures++; $display("FAIL fault_flags: got err=%b cov=%b expected 1/0100", err_sticky, cov_map); end
`ifdef GATE_CHK_FIRST_FAIL_EN
    checks++; if (first_fail_vec !== 5'b1_00_10) begin failures++; $display("FAIL fault_ffv: got %b expected 10010", first_fail_vec); end
`endif
    run_vec(1'b0, 1'b1, OP_AND, 1'b1, lat, rvc);
    checks++; if (fail_cnt !== 8'd2 || cov_map !== 4'b0110 || err_sticky !== 1'b1) begin failures++; $display("FAIL fault2: got fail=%0d cov=%b err=%b expected 2/0110/1", fail_cnt, cov_map, err_sticky); end
`ifdef GATE_CHK_FIRST_FAIL_EN
    checks++; if (first_fail_vec !== 5'b1_00_10) begin failures++; $display("FAIL fault_ffv_hold: got %b expected 10010", first_fail_vec); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [19:0] acc_mask;
    int ready_cycles;
    do_clear();
    acc_mask = '0;
    ready_cycles = 0;
    vec_a = 1'b1; vec_b = 1'b1; op_sel = OP_OR; obs_c = 1'b1; vec_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (vec_ready) begin
        acc_mask[i] = 1'b1;
        ready_cycles++;
      end
      @(posedge clk); #1;
    end
    vec_valid = 1'b0;
    checks++; if (acc_mask !== 20'h08421) begin failures++; $display("FAIL b2b_accepts: got %h expected 08421", acc_mask); end
    checks++; if (ready_cycles !== 4) begin failures++; $display("FAIL b2b_ready_cycles: got %0d expected 4", ready_cycles); end
    checks++; if (pass_cnt !== 8'd4 || err_sticky !== 1'b0) begin failures++; $display("FAIL b2b_cnt: got pass=%0d err=%b expected 4/0", pass_cnt, err_sticky); end
  endtask

  task automatic test_clear_mid();
    int rv_seen;
    vec_a = 1'b0; vec_b = 1'b1; op_sel = OP_OR; obs_c = 1'b1; vec_valid = 1'b1;
    @(posedge clk); #1;
    vec_valid = 1'b0;
    checks++; if (vec_ready !== 1'b0) begin failures++; $display("FAIL clr_mid_accept: got ready=%b expected 0", vec_ready); end
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    checks++; if (vec_ready !== 1'b1 || result_valid !== 1'b0) begin failures++; $display("FAIL clr_mid_idle: got rdy=%b rv=%b expected 1/0", vec_ready, result_valid); end
    rv_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (result_valid) rv_seen++;
    end
    checks++; if (rv_seen !== 0) begin failures++; $display("FAIL clr_mid_no_result: got %0d pulses expected 0", rv_seen); end
    checks++; if (pass_cnt !== 8'd0 || fail_cnt !== 8'd0 || cov_map !== 4'b0) begin failures++; $display("FAIL clr_mid_cnt: got %0d/%0d cov=%b expected 0/0/0000", pass_cnt, fail_cnt, cov_map); end
    vec_valid = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    vec_valid = 1'b0; clear = 1'b0;
    checks++; if (vec_ready !== 1'b1) begin failures++; $display("FAIL clr_vs_valid: got ready=%b expected 1", vec_ready); end
  endtask

  task automatic test_op_capture();
    int lat;
    do_clear();
    vec_a = 1'b1; vec_b = 1'b1; op_sel = OP_XOR; obs_c = 1'b0; vec_valid = 1'b1;
    @(posedge clk); #1;
    vec_valid = 1'b0;
    op_sel = OP_AND; vec_a = 1'b0; vec_b = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (result_valid) begin
        lat = i;
        break;
      end
    end
    checks++; if (lat !== 3) begin failures++; $display("FAIL opcap_latency: got %0d expected 3", lat); end
    checks++; if (result_pass !== 1'b1 || pass_cnt !== 8'd1) begin failures++; $display("FAIL opcap_pass: got rp=%b pass=%0d expected 1/1", result_pass, pass_cnt); end
    checks++; if (cov_map !== 4'b1000) begin failures++; $display("FAIL opcap_cov: got %b expected 1000", cov_map); end
    @(posedge clk); #1;
    checks++; if (result_pass !== 1'b1 || result_valid !== 1'b0) begin failures++; $display("FAIL opcap_hold: got rp=%b rv=%b expected 1/0", result_pass, result_valid); end
  endtask

  task automatic test_saturation();
    int lat, rvc;
    logic [1:0] v;
    do_clear();
    for (int i = 0; i < 258; i++) begin
      v = 2'(i);
      run_vec(v[1], v[0], OP_AND, v[1] & v[0], lat, rvc);
    end
    checks++; if (pass_cnt !== 8'd255 || fail_cnt !== 8'd0) begin failures++; $display("FAIL sat_pass: got %0d/%0d expected 255/0", pass_cnt, fail_cnt); end
    checks++; if (err_sticky !== 1'b0 || cov_done !== 1'b1) begin failures++; $display("FAIL sat_flags: got err=%b done=%b expected 0/1", err_sticky, cov_done); end
    run_vec(1'b1, 1'b1, OP_NAND, 1'b1, lat, rvc);
    checks++; if (pass_cnt !== 8'd255 || fail_cnt !== 8'd1 || err_sticky !== 1'b1) begin failures++; $display("FAIL sat_then_fail: got %0d/%0d err=%b expected 255/1/1", pass_cnt, fail_cnt, err_sticky); end
`ifdef GATE_CHK_FIRST_FAIL_EN
    checks++; if (first_fail_vec !== 5'b1_11_11) begin failures++; $display("FAIL sat_ffv: got %b expected 11111", first_fail_vec); end
`endif
  endtask

  task automatic test_reset_mid();
    vec_a = 1'b1; vec_b = 1'b0; op_sel = OP_XOR; obs_c = 1'b1; vec_valid = 1'b1;
    @(posedge clk); #1;
    vec_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++; if (vec_ready !== 1'b1 || result_valid !== 1'b0) begin failures++; $display("FAIL rstmid_ctrl: got rdy=%b rv=%b expected 1/0", vec_ready, result_valid); end
    checks++; if (pass_cnt !== 8'd0 || fail_cnt !== 8'd0 || err_sticky !== 1'b0 || cov_map !== 4'b0) begin failures++; $display("FAIL rstmid_state: got %0d/%0d err=%b cov=%b expected 0/0/0/0000", pass_cnt, fail_cnt, err_sticky, cov_map); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (pass_cnt !== 8'd0 || fail_cnt !== 8'd0) begin failures++; $display("FAIL rstmid_lost: got %0d/%0d expected 0/0", pass_cnt, fail_cnt); end
  endtask

  initial begin
    test_reset();
    test_or_sweep();
    test_fault();
    test_back_to_back();
    test_clear_mid();
    test_op_capture();
    test_saturation();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
